// File: rtl/gshare_predictor_pkg.sv
// Shared branch-predictor types: default table geometry, FSM states and the
// counter initial value (weakly not-taken).
package BranchPredictorTypes;

  localparam int PHT_ENTRIES = 256;
  localparam int PHT_IDX_W   = $clog2(PHT_ENTRIES);
  localparam int PHT_CTR_W   = 2;

  typedef logic [PHT_IDX_W-1:0] pht_idx_t;
  typedef logic [PHT_CTR_W-1:0] ctr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  function automatic int CTR_INIT(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch/execute-facing predictor bus: combinational lookup plus training port.
interface gshare_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 8
);

  logic [ADDR_W-1:0] pred_pc;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic              ready;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;

  modport master (
    output pred_pc, upd_valid, upd_idx, upd_taken,
    input  pred_taken, pred_idx, ready
  );

  modport slave (
    input  pred_pc, upd_valid, upd_idx, upd_taken,
    output pred_taken, pred_idx, ready
  );

endinterface

// File: rtl/gshare_predictor_sat.sv
// Saturating up/down step for one prediction counter; purely combinational.
module sat_counter_next #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_taken,
  output logic [CTR_W-1:0] o_next
);

  localparam logic [CTR_W-1:0] LP_MAX = '1;

  always_comb begin
    o_next = i_ctr;
    if (i_taken) begin
      if (i_ctr != LP_MAX) o_next = i_ctr + CTR_W'(1);
    end else begin
      if (i_ctr != '0) o_next = i_ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare/bimodal direction predictor: zero-latency lookup, trained at resolve,
// table swept to CTR_INIT after every reset before ready rises.
module gshare_predictor #(
  parameter int ENTRIES  = 256,
  parameter int CTR_W    = 2,
  parameter int HIST_LEN = 8,
  parameter int GSHARE   = 1,
  parameter int ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  gshare_predictor_if.slave  bp
);
  import BranchPredictorTypes::*;

  localparam int               IDX_W       = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] LP_CTR_INIT = CTR_W'(CTR_INIT(CTR_W));

  bp_state_t           r_state;
  bp_state_t           w_state_nxt;
  logic [IDX_W-1:0]    r_init_ptr;
  logic [HIST_LEN-1:0] r_ghr;
  logic [CTR_W-1:0]    r_pht [ENTRIES];

  logic                w_ready;
  logic                w_init_we;
  logic                w_train;
  logic [IDX_W-1:0]    w_base;
  logic [IDX_W-1:0]    w_ghr_ext;
  logic [IDX_W-1:0]    w_pred_idx;
  logic [CTR_W-1:0]    w_ctr_nxt;
  logic [HIST_LEN-1:0] w_ghr_nxt;
  logic                w_unused_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_init_we   = 1'b0;
    case (r_state)
      INIT: begin
        w_init_we = 1'b1;
        if (r_init_ptr == IDX_W'(ENTRIES - 1)) w_state_nxt = RUN;
      end
      RUN:     w_ready = 1'b1;
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_init_ptr <= '0;
    else if (w_init_we) r_init_ptr <= r_init_ptr + IDX_W'(1);
  end

  assign w_train   = w_ready & bp.upd_valid;
  assign w_ghr_nxt = HIST_LEN'({r_ghr, bp.upd_taken});

  // History only advances on resolved branches, so it never needs repair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ghr <= '0;
    else if (w_train) r_ghr <= w_ghr_nxt;
  end

  sat_counter_next #(.CTR_W(CTR_W)) u_sat (
    .i_ctr   (r_pht[bp.upd_idx]),
    .i_taken (bp.upd_taken),
    .o_next  (w_ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (w_init_we)    r_pht[r_init_ptr] <= LP_CTR_INIT;
    else if (w_train) r_pht[bp.upd_idx] <= w_ctr_nxt;
  end

  assign w_base      = bp.pred_pc[IDX_W+1:2];
  assign w_ghr_ext   = IDX_W'(r_ghr);
  assign w_pred_idx  = (GSHARE != 0) ? (w_base ^ w_ghr_ext) : w_base;
  assign w_unused_pc = ^{bp.pred_pc[ADDR_W-1:IDX_W+2], bp.pred_pc[1:0]};

  // Lookup reads the table before any same-cycle write lands: no bypass.
  assign bp.pred_idx   = w_pred_idx;
  assign bp.pred_taken = w_ready & r_pht[w_pred_idx][CTR_W-1];
  assign bp.ready      = w_ready;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench: gshare (default), bimodal and a small 3-bit-counter instance.
module tb_gshare_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  gshare_predictor_if #(.ADDR_W(32), .IDX_W(8)) if_g ();
  gshare_predictor_if #(.ADDR_W(32), .IDX_W(8)) if_b ();
  gshare_predictor_if #(.ADDR_W(32), .IDX_W(4)) if_s ();

  gshare_predictor #(.ENTRIES(256), .CTR_W(2), .HIST_LEN(8), .GSHARE(1), .ADDR_W(32))
    dut_g (.clk(clk), .rst(rst), .bp(if_g.slave));
  gshare_predictor #(.ENTRIES(256), .CTR_W(2), .HIST_LEN(8), .GSHARE(0), .ADDR_W(32))
    dut_b (.clk(clk), .rst(rst), .bp(if_b.slave));
  gshare_predictor #(.ENTRIES(16), .CTR_W(3), .HIST_LEN(4), .GSHARE(1), .ADDR_W(32))
    dut_s (.clk(clk), .rst(rst), .bp(if_s.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd_g(input logic [7:0] idx, input logic t);
    if_g.upd_valid = 1'b1; if_g.upd_idx = idx; if_g.upd_taken = t;
    tick();
    if_g.upd_valid = 1'b0;
    #1;
  endtask

  task automatic upd_b(input logic [7:0] idx, input logic t);
    if_b.upd_valid = 1'b1; if_b.upd_idx = idx; if_b.upd_taken = t;
    tick();
    if_b.upd_valid = 1'b0;
    #1;
  endtask

  task automatic upd_s(input logic [3:0] idx, input logic t);
    if_s.upd_valid = 1'b1; if_s.upd_idx = idx; if_s.upd_taken = t;
    tick();
    if_s.upd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_g.pred_pc = 32'h40; if_b.pred_pc = 32'h40; if_s.pred_pc = 32'h8;
    if_g.upd_valid = 1'b0; if_g.upd_idx = '0; if_g.upd_taken = 1'b0;
    if_b.upd_valid = 1'b0; if_b.upd_idx = '0; if_b.upd_taken = 1'b0;
    if_s.upd_valid = 1'b0; if_s.upd_idx = '0; if_s.upd_taken = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (if_g.ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_g: got %b expected 0", if_g.ready); end
    n_checks++;
    if (if_g.pred_taken !== 1'b0) begin n_errors++; $display("FAIL reset_taken_g: got %b expected 0", if_g.pred_taken); end
    n_checks++;
    if (if_g.pred_idx !== 8'h10) begin n_errors++; $display("FAIL reset_idx_g: got %h expected 10", if_g.pred_idx); end
    n_checks++;
    if (if_s.pred_idx !== 4'h2) begin n_errors++; $display("FAIL reset_idx_s: got %h expected 2", if_s.pred_idx); end
    n_checks++;
    if (if_b.ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_b: got %b expected 0", if_b.ready); end
    rst = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 15 || k == 16) begin
        n_checks++;
        if (if_s.ready !== (k >= 16)) begin n_errors++; $display("FAIL init_ready_s k=%0d: got %b expected %b", k, if_s.ready, (k >= 16)); end
      end
      if (k == 255 || k == 256) begin
        n_checks++;
        if (if_g.ready !== (k >= 256)) begin n_errors++; $display("FAIL init_ready_g k=%0d: got %b expected %b", k, if_g.ready, (k >= 256)); end
        n_checks++;
        if (if_b.ready !== (k >= 256)) begin n_errors++; $display("FAIL init_ready_b k=%0d: got %b expected %b", k, if_b.ready, (k >= 256)); end
      end
    end
  endtask

  task automatic test_init_values();
    for (int i = 0; i < 256; i++) begin
      if_g.pred_pc = 32'(i * 4);
      #1;
      n_checks++;
      if (if_g.pred_taken !== 1'b0) begin n_errors++; $display("FAIL init_taken pc=%h: got %b expected 0", if_g.pred_pc, if_g.pred_taken); end
      n_checks++;
      if (if_g.pred_idx !== 8'(i)) begin n_errors++; $display("FAIL init_idx pc=%h: got %h expected %h", if_g.pred_pc, if_g.pred_idx, 8'(i)); end
    end
  endtask

  task automatic test_bimodal();
    logic tk  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exp [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    if_b.pred_pc = 32'h40;
    #1;
    for (int i = 0; i < 10; i++) begin
      upd_b(8'h10, tk[i]);
      n_checks++;
      if (if_b.pred_taken !== exp[i]) begin n_errors++; $display("FAIL bimodal_taken step=%0d: got %b expected %b", i, if_b.pred_taken, exp[i]); end
      n_checks++;
      if (if_b.pred_idx !== 8'h10) begin n_errors++; $display("FAIL bimodal_idx step=%0d: got %h expected 10", i, if_b.pred_idx); end
    end
  endtask

  task automatic test_gshare();
    logic [7:0] exp_idx [3] = '{8'h41, 8'h43, 8'h47};
    if_g.pred_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      upd_g(8'h80, 1'b1);
      n_checks++;
      if (if_g.pred_idx !== exp_idx[i]) begin n_errors++; $display("FAIL gshare_idx step=%0d: got %h expected %h", i, if_g.pred_idx, exp_idx[i]); end
    end
    if_g.upd_valid = 1'b1; if_g.upd_idx = 8'h47; if_g.upd_taken = 1'b1;
    #1;
    n_checks++;
    if (if_g.pred_taken !== 1'b0) begin n_errors++; $display("FAIL same_cycle_taken: got %b expected 0", if_g.pred_taken); end
    tick();
    if_g.upd_valid = 1'b0;
    if_g.pred_pc = 32'h120;
    #1;
    n_checks++;
    if (if_g.pred_idx !== 8'h47) begin n_errors++; $display("FAIL next_cycle_idx: got %h expected 47", if_g.pred_idx); end
    n_checks++;
    if (if_g.pred_taken !== 1'b1) begin n_errors++; $display("FAIL next_cycle_taken: got %b expected 1", if_g.pred_taken); end
    if_g.pred_pc = 32'h100;
    #1;
    n_checks++;
    if (if_g.pred_idx !== 8'h4F) begin n_errors++; $display("FAIL ghr4_idx: got %h expected 4f", if_g.pred_idx); end
    n_checks++;
    if (if_g.pred_taken !== 1'b0) begin n_errors++; $display("FAIL ghr4_taken: got %b expected 0", if_g.pred_taken); end
    if_g.pred_pc = 32'h0;
    repeat (4) upd_g(8'h80, 1'b0);
    n_checks++;
    if (if_g.pred_idx !== 8'hF0) begin n_errors++; $display("FAIL ghr_shift_idx: got %h expected f0", if_g.pred_idx); end
    repeat (4) upd_g(8'h80, 1'b0);
    n_checks++;
    if (if_g.pred_idx !== 8'h00) begin n_errors++; $display("FAIL ghr_trunc_idx: got %h expected 00", if_g.pred_idx); end
  endtask

  task automatic test_small();
    if_s.pred_pc = 32'h8;
    #1;
    n_checks++;
    if (if_s.pred_idx !== 4'h2 || if_s.pred_taken !== 1'b0) begin n_errors++; $display("FAIL small_init: got idx %h taken %b expected idx 2 taken 0", if_s.pred_idx, if_s.pred_taken); end
    upd_s(4'h2, 1'b1);
    if_s.pred_pc = 32'hC;
    #1;
    n_checks++;
    if (if_s.pred_idx !== 4'h2 || if_s.pred_taken !== 1'b1) begin n_errors++; $display("FAIL small_taken: got idx %h taken %b expected idx 2 taken 1", if_s.pred_idx, if_s.pred_taken); end
    if_s.pred_pc = 32'h8;
    #1;
    n_checks++;
    if (if_s.pred_idx !== 4'h3 || if_s.pred_taken !== 1'b0) begin n_errors++; $display("FAIL small_other: got idx %h taken %b expected idx 3 taken 0", if_s.pred_idx, if_s.pred_taken); end
    upd_s(4'h2, 1'b0);
    if_s.pred_pc = 32'h0;
    #1;
    n_checks++;
    if (if_s.pred_idx !== 4'h2 || if_s.pred_taken !== 1'b0) begin n_errors++; $display("FAIL small_back: got idx %h taken %b expected idx 2 taken 0", if_s.pred_idx, if_s.pred_taken); end
  endtask

  task automatic test_reset_mid();
    if_g.pred_pc = 32'h120;
    rst = 1'b1;
    #1;
    n_checks++;
    if (if_g.ready !== 1'b0 || if_g.pred_taken !== 1'b0) begin n_errors++; $display("FAIL async_rst: got ready %b taken %b expected 0 0", if_g.ready, if_g.pred_taken); end
    repeat (2) tick();
    rst = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (if_g.ready !== 1'b0) begin n_errors++; $display("FAIL mid_init_rst_ready: got %b expected 0", if_g.ready); end
    tick();
    rst = 1'b0;
    if_g.upd_idx = 8'h47; if_g.upd_taken = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      if_g.upd_valid = (k <= 10);
      tick();
      if (k == 255 || k == 256) begin
        n_checks++;
        if (if_g.ready !== (k >= 256)) begin n_errors++; $display("FAIL resweep_ready k=%0d: got %b expected %b", k, if_g.ready, (k >= 256)); end
      end
    end
    if_g.upd_valid = 1'b0;
    if_g.pred_pc = 32'h100;
    #1;
    n_checks++;
    if (if_g.pred_idx !== 8'h40) begin n_errors++; $display("FAIL init_upd_dropped_idx: got %h expected 40", if_g.pred_idx); end
    if_g.pred_pc = 32'h11C;
    #1;
    n_checks++;
    if (if_g.pred_taken !== 1'b0) begin n_errors++; $display("FAIL resweep_taken_g: got %b expected 0", if_g.pred_taken); end
    n_checks++;
    if (if_b.pred_taken !== 1'b0) begin n_errors++; $display("FAIL resweep_taken_b: got %b expected 0", if_b.pred_taken); end
    n_checks++;
    if (if_s.ready !== 1'b1) begin n_errors++; $display("FAIL resweep_ready_s: got %b expected 1", if_s.ready); end
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_bimodal();
    test_gshare();
    test_small();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
